// File: rtl/bali_pkg.sv
// rtl/bali_pkg.sv - shared widths and invoke argument mover state encoding
package bali_pkg;

   localparam int DATAW_DEF    = 32;
   localparam int ADDRW_DEF    = 8;
   localparam int LVA_SIZE_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_POP_REQ,
      ST_POP_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_FINISH
   } invoke_state_t;

endpackage

// File: rtl/invoke_arg_mover.sv
// rtl/invoke_arg_mover.sv - pops invokestatic arguments off the eval stack into the LVA
module invoke_arg_mover
   import bali_pkg::*;
#(
   parameter int DATAW    = DATAW_DEF,
   parameter int ADDRW    = ADDRW_DEF,
   parameter int LVA_SIZE = LVA_SIZE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADDRW-1:0] argcount,
   input  logic [ADDRW-1:0] baseindex,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [ADDRW-1:0] moved,
   output logic             evalpush,
   output logic             evaltrigger,
   input  logic [DATAW-1:0] evalread,
   input  logic             evaldone,
   output logic             lvaop,
   output logic             lvatrigger,
   output logic [ADDRW-1:0] lvaindex,
   output logic [DATAW-1:0] lvawrite,
   input  logic             lvadone
);

   localparam logic [ADDRW:0] LVA_LIMIT = (ADDRW+1)'(LVA_SIZE);
   localparam logic [ADDRW:0] IDX_ONE   = (ADDRW+1)'(1);

   invoke_state_t    state_q, state_d;
   logic [ADDRW-1:0] remaining_q, remaining_d;
   logic [ADDRW:0]   idx_q, idx_d;
   logic [DATAW-1:0] data_q, data_d;
   logic [ADDRW-1:0] moved_q, moved_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         idx_q       <= '0;
         data_q      <= '0;
         moved_q     <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         moved_q     <= moved_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      idx_d       = idx_q;
      data_d      = data_q;
      moved_d     = moved_q;
      busy        = (state_q != ST_IDLE);
      done        = 1'b0;
      error       = 1'b0;
      evaltrigger = 1'b0;
      lvaop       = 1'b0;
      lvatrigger  = 1'b0;
      lvaindex    = '0;
      lvawrite    = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               remaining_d = argcount;
               // idx holds the highest target slot; the extra bit keeps the range check wrap-free
               idx_d       = {1'b0, baseindex} + {1'b0, argcount} - IDX_ONE;
               moved_d     = '0;
               state_d     = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (remaining_q == '0) begin
               state_d = ST_FINISH;
            end else if ((idx_q + IDX_ONE) > LVA_LIMIT) begin
               error   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_POP_REQ;
            end
         end
         ST_POP_REQ: begin
            evaltrigger = 1'b1;
            state_d     = ST_POP_WAIT;
         end
         ST_POP_WAIT: begin
            if (evaldone) begin
               data_d  = evalread;
               state_d = ST_WR_REQ;
            end
         end
         ST_WR_REQ: begin
            lvaop      = 1'b1;
            lvatrigger = 1'b1;
            lvaindex   = idx_q[ADDRW-1:0];
            lvawrite   = data_q;
            state_d    = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            lvaop    = 1'b1;
            lvaindex = idx_q[ADDRW-1:0];
            lvawrite = data_q;
            if (lvadone) begin
               moved_d     = moved_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               idx_d       = idx_q - IDX_ONE;
               state_d     = (remaining_q == ADDRW'(1)) ? ST_FINISH : ST_POP_REQ;
            end
         end
         ST_FINISH: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign evalpush = 1'b0;
   assign moved    = moved_q;

endmodule

// File: tb/tb_invoke_arg_mover.sv
// tb/tb_invoke_arg_mover.sv - scoreboard bench with stack and LVA models for invoke_arg_mover
module tb_invoke_arg_mover;

   typedef struct {
      logic       is_err;
      logic [7:0] moved;
   } res_t;

   typedef struct {
      logic [7:0]  idx;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  argcount;
   logic [7:0]  baseindex;
   logic        busy, done, error;
   logic [7:0]  moved;
   logic        evalpush, evaltrigger;
   logic [31:0] evalread;
   logic        evaldone;
   logic        lvaop, lvatrigger;
   logic [7:0]  lvaindex;
   logic [31:0] lvawrite;
   logic        lvadone;

   int tests = 0;
   int fails = 0;
   int cyc_cnt = 0;
   int t0 = 0;
   int ev_trig_cnt = 0;
   int lva_trig_cnt = 0;
   int pop_done_cnt = 0;
   int model_pops = 0;
   int stall_on_pop = 0;
   int lva_delay = 0;

   logic [31:0] stk[$];
   logic [31:0] lva[0:7];
   res_t        exp_res[$];
   wr_t         exp_wr[$];

   invoke_arg_mover dut (
      .clk(clk), .rst(rst), .start(start), .argcount(argcount), .baseindex(baseindex),
      .busy(busy), .done(done), .error(error), .moved(moved),
      .evalpush(evalpush), .evaltrigger(evaltrigger), .evalread(evalread), .evaldone(evaldone),
      .lvaop(lvaop), .lvatrigger(lvatrigger), .lvaindex(lvaindex), .lvawrite(lvawrite),
      .lvadone(lvadone)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc_cnt++;
      if (evaldone && !rst) pop_done_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // stack model: level done arrives one cycle after the trigger plus any stall
   initial begin
      evaldone = 1'b0;
      evalread = '0;
      forever begin
         @(negedge clk);
         evaldone = 1'b0;
         if (!rst && evaltrigger && !evalpush) begin
            model_pops++;
            @(negedge clk);
            if (model_pops == stall_on_pop) repeat (5) @(negedge clk);
            evalread = (stk.size() > 0) ? stk.pop_back() : 32'h0;
            evaldone = 1'b1;
         end
      end
   end

   initial begin
      lvadone = 1'b0;
      for (int i = 0; i < 8; i++) lva[i] = 32'h0;
      forever begin
         @(negedge clk);
         lvadone = 1'b0;
         if (!rst && lvatrigger && lvaop) begin
            if (lvaindex < 8) lva[lvaindex[2:0]] = lvawrite;
            @(negedge clk);
            repeat (lva_delay) @(negedge clk);
            lvadone = 1'b1;
         end
      end
   end

   // monitor: scoreboard pops on every write request and every done/error pulse
   initial forever begin
      wr_t  w;
      res_t r;
      @(negedge clk);
      if (!rst) begin
         if (evaltrigger) ev_trig_cnt++;
         if (lvatrigger) begin
            lva_trig_cnt++;
            check("lva_after_pop", 64'(lva_trig_cnt), 64'(pop_done_cnt));
            check("lvaop_on_trig", 64'(lvaop), 64'(1));
            check("trig_overlap", 64'(evaltrigger), 64'(0));
            if (exp_wr.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got idx %0d data %0h expected none", lvaindex, lvawrite);
            end else begin
               w = exp_wr.pop_front();
               check("wr_index", 64'(lvaindex), 64'(w.idx));
               check("wr_data", 64'(lvawrite), 64'(w.data));
            end
         end
         if (done || error) begin
            if (exp_res.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_end: got done %0d error %0d expected none", done, error);
            end else begin
               r = exp_res.pop_front();
               check("end_kind", 64'({done, error}), 64'({!r.is_err, r.is_err}));
               check("end_moved", 64'(moved), 64'(r.moved));
            end
         end
      end
   end

   task automatic do_start(input logic [7:0] cnt, input logic [7:0] base);
      @(negedge clk);
      start = 1'b1;
      argcount = cnt;
      baseindex = base;
      t0 = cyc_cnt;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'(1));
   endtask

   task automatic wait_end(output int lat);
      int n = 0;
      while (!(done || error) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!(done || error)) begin
         tests++;
         fails++;
         $display("FAIL timeout: got no done/error expected one within 300 cycles");
      end
      lat = cyc_cnt - t0;
   endtask

   initial begin
      int lat, e0, l0, n;
      wr_t  w;
      res_t r;
      rst = 1'b1;
      start = 1'b0;
      argcount = '0;
      baseindex = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            64'({busy, done, error, evalpush, evaltrigger, lvaop, lvatrigger}), 64'(0));
      check("reset_moved", 64'(moved), 64'(0));
      check("reset_lva_bus", 64'({lvaindex, lvawrite}), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // two args to slots 0..1, top of stack lands highest
      stk = '{32'd4, 32'd5};
      w = '{8'd1, 32'd5}; exp_wr.push_back(w);
      w = '{8'd0, 32'd4}; exp_wr.push_back(w);
      r = '{1'b0, 8'd2};  exp_res.push_back(r);
      e0 = ev_trig_cnt; l0 = lva_trig_cnt;
      do_start(8'd2, 8'd0);
      wait_end(lat);
      check("t1_latency", 64'(lat), 64'(10));
      @(negedge clk);
      check("t1_lva1", 64'(lva[1]), 64'(5));
      check("t1_lva0", 64'(lva[0]), 64'(4));
      check("t1_pops", 64'(ev_trig_cnt - e0), 64'(2));
      check("t1_writes", 64'(lva_trig_cnt - l0), 64'(2));
      check("t1_stack_empty", 64'(stk.size()), 64'(0));
      check("t1_moved_hold", 64'(moved), 64'(2));
      check("t1_idle", 64'({busy, done}), 64'(0));

      // zero arguments
      r = '{1'b0, 8'd0}; exp_res.push_back(r);
      e0 = ev_trig_cnt; l0 = lva_trig_cnt;
      do_start(8'd0, 8'd3);
      wait_end(lat);
      check("t2_latency", 64'(lat), 64'(2));
      check("t2_moved", 64'(moved), 64'(0));
      @(negedge clk);
      check("t2_no_trigs", 64'((ev_trig_cnt - e0) + (lva_trig_cnt - l0)), 64'(0));

      // range check failure: 7 + 2 > 8
      stk = '{32'h99};
      r = '{1'b1, 8'd0}; exp_res.push_back(r);
      e0 = ev_trig_cnt; l0 = lva_trig_cnt;
      do_start(8'd2, 8'd7);
      wait_end(lat);
      check("t3_latency", 64'(lat), 64'(1));
      @(negedge clk);
      check("t3_idle", 64'({busy, error}), 64'(0));
      check("t3_no_trigs", 64'((ev_trig_cnt - e0) + (lva_trig_cnt - l0)), 64'(0));
      check("t3_stack_size", 64'(stk.size()), 64'(1));
      check("t3_stack_top", 64'(stk[0]), 64'(32'h99));

      // three args ending exactly at the last slot, with a stray start mid-transfer
      stk = '{32'hDEADBEEF, 32'h1, 32'h2};
      w = '{8'd7, 32'h2};        exp_wr.push_back(w);
      w = '{8'd6, 32'h1};        exp_wr.push_back(w);
      w = '{8'd5, 32'hDEADBEEF}; exp_wr.push_back(w);
      r = '{1'b0, 8'd3}; exp_res.push_back(r);
      e0 = ev_trig_cnt;
      do_start(8'd3, 8'd5);
      repeat (2) @(negedge clk);
      start = 1'b1; argcount = 8'd1; baseindex = 8'd0;
      @(negedge clk);
      start = 1'b0;
      wait_end(lat);
      check("t4_latency", 64'(lat), 64'(14));
      @(negedge clk);
      check("t4_lva7", 64'(lva[7]), 64'(32'h2));
      check("t4_lva6", 64'(lva[6]), 64'(32'h1));
      check("t4_lva5", 64'(lva[5]), 64'(32'hDEADBEEF));
      check("t4_lva0_untouched", 64'(lva[0]), 64'(4));
      check("t4_pops", 64'(ev_trig_cnt - e0), 64'(3));
      repeat (3) @(negedge clk);
      check("t4_single_done", 64'(exp_res.size()), 64'(0));

      // second pop stalls five extra cycles
      stk = '{32'h11, 32'h22};
      stall_on_pop = model_pops + 2;
      w = '{8'd3, 32'h22}; exp_wr.push_back(w);
      w = '{8'd2, 32'h11}; exp_wr.push_back(w);
      r = '{1'b0, 8'd2}; exp_res.push_back(r);
      e0 = ev_trig_cnt;
      do_start(8'd2, 8'd2);
      wait_end(lat);
      check("t5_latency", 64'(lat), 64'(15));
      @(negedge clk);
      check("t5_pops", 64'(ev_trig_cnt - e0), 64'(2));
      check("t5_lva3", 64'(lva[3]), 64'(32'h22));
      check("t5_lva2", 64'(lva[2]), 64'(32'h11));

      // reset while waiting on the first LVA write
      stk = '{32'hA, 32'hB};
      lva_delay = 3;
      w = '{8'd1, 32'hB}; exp_wr.push_back(w);
      do_start(8'd2, 8'd0);
      n = 0;
      while (!(lvaop && !lvatrigger) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t6_reached_wr_wait", 64'(lvaop && !lvatrigger), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("t6_reset_outputs",
            64'({busy, done, error, evaltrigger, lvatrigger, lvaop}), 64'(0));
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("t6_no_extra_writes", 64'(exp_wr.size()), 64'(0));
      check("t6_quiet", 64'({busy, done, error}), 64'(0));

      stk.delete();
      lva_delay = 0;
      stk.push_back(32'h77);
      w = '{8'd3, 32'h77}; exp_wr.push_back(w);
      r = '{1'b0, 8'd1}; exp_res.push_back(r);
      do_start(8'd1, 8'd3);
      wait_end(lat);
      check("t6b_latency", 64'(lat), 64'(6));
      @(negedge clk);
      check("t6b_lva3", 64'(lva[3]), 64'(32'h77));
      check("t6b_moved", 64'(moved), 64'(1));

      repeat (4) @(negedge clk);
      check("sb_results_drained", 64'(exp_res.size()), 64'(0));
      check("sb_writes_drained", 64'(exp_wr.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
